// File: rtl/cu_wb.sv
// cu_wb: writeback-side consumer of the execute stage.
// Latches destination info when EX starts, waits for the ALU result, then
// commits one register-file write, a branch redirect or a trap. A hung EX is
// aborted after TIMEOUT_CYCLES waiting cycles.
// Optional feature: define CU_WB_FORWARD_EN to add the fwd_valid/fwd_rd/fwd_data
// forwarding outputs.
module cu_wb #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter bit TRAP_ON_OVF    = 1'b0
) (
  input  logic        soc_clk,
  input  logic        WB_reset,
  input  logic        wb_start,
  input  logic [4:0]  rd_addr,
  input  logic        rd_write,
  input  logic        is_branch,
  input  logic [31:0] result_data,
  input  logic        result_ready,
  input  logic        overflow_flag,
  input  logic        zero_flag,
  input  logic        condition_met_flag,
  input  logic        error_flag,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        branch_taken,
  output logic        wb_zero,
  output logic        wb_trap,
  output logic [1:0]  trap_cause,
  output logic        wb_busy,
  output logic        wb_done
`ifdef CU_WB_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Last timer value that is still allowed to wait; reaching it without a
  // result means EX is considered hung.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ERROR   = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  logic [1:0]  state;
  logic [7:0]  timer;
  logic [4:0]  lat_rd;
  logic        lat_wr;
  logic        lat_br;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        res_zero;
  logic        res_cond;
  logic        res_err;

  assign wb_busy = (state == S_WAIT) || (state == S_COMMIT);

  // Writeback sequencer: latch, wait, decide, then pulse the registered strobes
  // during the single DONE cycle.
  always_ff @(posedge soc_clk) begin
    if (WB_reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      lat_rd       <= '0;
      lat_wr       <= 1'b0;
      lat_br       <= 1'b0;
      res_data     <= '0;
      res_ovf      <= 1'b0;
      res_zero     <= 1'b0;
      res_cond     <= 1'b0;
      res_err      <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      branch_taken <= 1'b0;
      wb_zero      <= 1'b0;
      wb_trap      <= 1'b0;
      trap_cause   <= CAUSE_NONE;
      wb_done      <= 1'b0;
`ifdef CU_WB_FORWARD_EN
      fwd_valid    <= 1'b0;
      fwd_rd       <= '0;
      fwd_data     <= '0;
`endif
    end else begin
      rf_wr_en     <= 1'b0;
      branch_taken <= 1'b0;
      wb_trap      <= 1'b0;
      wb_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_start) begin
            lat_rd <= rd_addr;
            lat_wr <= rd_write;
            lat_br <= is_branch;
            timer  <= '0;
            state  <= S_WAIT;
`ifdef CU_WB_FORWARD_EN
            fwd_valid <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (result_ready) begin
            res_data <= result_data;
            res_ovf  <= overflow_flag;
            res_zero <= zero_flag;
            res_cond <= condition_met_flag;
            res_err  <= error_flag;
            state    <= S_COMMIT;
          end else if (timer == TIMER_LAST) begin
            trap_cause <= CAUSE_TIMEOUT;
            wb_trap    <= 1'b1;
            wb_done    <= 1'b1;
            state      <= S_DONE;
`ifdef CU_WB_FORWARD_EN
            fwd_valid  <= 1'b0;
`endif
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_COMMIT: begin
          wb_done <= 1'b1;
          wb_zero <= res_zero;
          state   <= S_DONE;
          if (res_err) begin
            wb_trap    <= 1'b1;
            trap_cause <= CAUSE_ERROR;
`ifdef CU_WB_FORWARD_EN
            fwd_valid  <= 1'b0;
`endif
          end else if (res_ovf && TRAP_ON_OVF) begin
            wb_trap    <= 1'b1;
            trap_cause <= CAUSE_OVF;
`ifdef CU_WB_FORWARD_EN
            fwd_valid  <= 1'b0;
`endif
          end else begin
            trap_cause   <= CAUSE_NONE;
            branch_taken <= lat_br && res_cond;
            if (lat_wr && (lat_rd != 5'd0)) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= lat_rd;
              rf_wr_data <= res_data;
`ifdef CU_WB_FORWARD_EN
              fwd_valid  <= 1'b1;
              fwd_rd     <= lat_rd;
              fwd_data   <= res_data;
`endif
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_wb.sv
// tb_cu_wb: scoreboard bench for cu_wb. Stimulus pushes the expected outcome of
// each instruction; a monitor pops and compares on every wb_done pulse.
module tb_cu_wb;

  localparam int TIMEOUT  = 8;
  localparam bit TRAP_OVF = 1'b1;

  logic        soc_clk = 1'b0;
  logic        WB_reset;
  logic        wb_start;
  logic [4:0]  rd_addr;
  logic        rd_write;
  logic        is_branch;
  logic [31:0] result_data;
  logic        result_ready;
  logic        overflow_flag;
  logic        zero_flag;
  logic        condition_met_flag;
  logic        error_flag;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        branch_taken;
  logic        wb_zero;
  logic        wb_trap;
  logic [1:0]  trap_cause;
  logic        wb_busy;
  logic        wb_done;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          br;
    bit          trap;
    logic [1:0]  cause;
    bit          zero;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   last_zero = 1'b0;

  cu_wb #(.TIMEOUT_CYCLES(TIMEOUT), .TRAP_ON_OVF(TRAP_OVF)) dut (
    .soc_clk(soc_clk), .WB_reset(WB_reset), .wb_start(wb_start),
    .rd_addr(rd_addr), .rd_write(rd_write), .is_branch(is_branch),
    .result_data(result_data), .result_ready(result_ready),
    .overflow_flag(overflow_flag), .zero_flag(zero_flag),
    .condition_met_flag(condition_met_flag), .error_flag(error_flag),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .branch_taken(branch_taken), .wb_zero(wb_zero), .wb_trap(wb_trap),
    .trap_cause(trap_cause), .wb_busy(wb_busy), .wb_done(wb_done)
  );

  always #5 soc_clk = ~soc_clk;

  always @(posedge soc_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference outcome of one instruction, straight from the writeback rules.
  function automatic exp_t model(input logic [4:0] rd, input bit wr, input bit br,
                                 input logic [31:0] data, input bit ovf, input bit zero,
                                 input bit cond, input bit err, input bit hang);
    exp_t e;
    bit trap;
    e.addr = rd;
    e.data = data;
    if (hang) begin
      e.trap = 1; e.cause = 2'b11; e.wr = 0; e.br = 0; e.zero = last_zero;
    end else begin
      trap   = err || (ovf && TRAP_OVF);
      e.trap = trap;
      e.cause = err ? 2'b01 : (trap ? 2'b10 : 2'b00);
      e.wr   = !trap && wr && (rd != 0);
      e.br   = !trap && br && cond;
      e.zero = zero;
    end
    e.cyc = 0;
    return e;
  endfunction

  task automatic noise_inputs();
    rd_addr = 5'($urandom); rd_write = 1'($urandom); is_branch = 1'($urandom);
    result_data = $urandom; overflow_flag = 1'($urandom); zero_flag = 1'($urandom);
    condition_met_flag = 1'($urandom); error_flag = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge soc_clk); #1;
  endtask

  // Drives one instruction from start to return-to-IDLE and queues its outcome.
  task automatic apply_stimulus(input logic [4:0] rd, input bit wr, input bit br,
                                input logic [31:0] data, input bit ovf, input bit zero,
                                input bit cond, input bit err, input int d, input bit hang);
    exp_t e;
    e = model(rd, wr, br, data, ovf, zero, cond, err, hang);
    e.cyc = hang ? cyc + 1 + TIMEOUT : cyc + 3 + d;
    if (!hang) last_zero = zero;
    exp_q.push_back(e);
    noise_inputs();
    wb_start = 1; rd_addr = rd; rd_write = wr; is_branch = br;
    result_ready = ($urandom_range(0, 2) == 0);
    tick();
    for (int i = 0; i < (hang ? TIMEOUT : d); i++) begin
      noise_inputs();
      wb_start = ($urandom_range(0, 2) == 0);
      result_ready = 0;
      tick();
    end
    if (!hang) begin
      wb_start = 0; result_ready = 1; result_data = data;
      overflow_flag = ovf; zero_flag = zero; condition_met_flag = cond; error_flag = err;
      tick();
      noise_inputs(); result_ready = 0; wb_start = 1'($urandom);
      tick();
      noise_inputs(); result_ready = 1'($urandom); wb_start = 1'($urandom);
      tick();
    end else begin
      noise_inputs(); result_ready = 1; wb_start = 1'($urandom);
      tick();
      noise_inputs(); result_ready = 1; wb_start = 0;
      tick();
    end
    wb_start = 0; result_ready = 0;
    repeat ($urandom_range(0, 2)) begin
      noise_inputs(); result_ready = 1'($urandom);
      tick();
    end
    result_ready = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_busy"}, wb_busy, 0);
    check_output({tag, "_strobes"}, {rf_wr_en, branch_taken, wb_trap, wb_done}, 0);
    check_output({tag, "_held"}, {rf_wr_addr, trap_cause, wb_zero}, 0);
    check_output({tag, "_wdata"}, rf_wr_data, 0);
  endtask

  // Monitor: every wb_done pops one expected outcome; strobes must stay low otherwise.
  always @(negedge soc_clk) begin
    exp_t e;
    if (!WB_reset) begin
      if (wb_done) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("done_cycle", cyc, e.cyc);
          check_output("rf_wr_en", rf_wr_en, e.wr);
          if (e.wr) begin
            check_output("rf_wr_addr", rf_wr_addr, e.addr);
            check_output("rf_wr_data", rf_wr_data, e.data);
          end
          check_output("branch_taken", branch_taken, e.br);
          check_output("wb_trap", wb_trap, e.trap);
          check_output("trap_cause", trap_cause, e.cause);
          check_output("wb_zero", wb_zero, e.zero);
        end
      end else if (rf_wr_en || branch_taken || wb_trap) begin
        check_output("stray_strobe", {rf_wr_en, branch_taken, wb_trap}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    WB_reset = 1; wb_start = 0; result_ready = 0;
    noise_inputs();
    repeat (3) tick();
    check_reset_state("reset");
    WB_reset = 0;
    result_ready = 1;
    tick();
    result_ready = 0;
    check_output("idle_ready_ignored_busy", wb_busy, 0);

    apply_stimulus(5'd5, 1, 0, 32'h0000_0030, 0, 0, 0, 0, 1, 0);
    apply_stimulus(5'd0, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);
    apply_stimulus(5'd3, 0, 1, 32'h0, 0, 1, 1, 0, 2, 0);
    apply_stimulus(5'd3, 0, 1, 32'h4, 0, 0, 0, 0, 0, 0);
    apply_stimulus(5'd7, 1, 0, 32'h1234, 0, 1, 0, 1, 3, 0);
    apply_stimulus(5'd9, 1, 1, 32'h7FFF_FFFF, 1, 0, 1, 0, TIMEOUT - 1, 0);
    apply_stimulus(5'd4, 1, 0, 32'h55, 0, 0, 0, 0, 0, 1);

    wb_start = 1; rd_addr = 5'd12; rd_write = 1; is_branch = 0;
    tick();
    wb_start = 0;
    check_output("busy_in_wait", wb_busy, 1);
    tick();
    WB_reset = 1;
    tick();
    WB_reset = 0;
    check_reset_state("midop_reset");
    last_zero = 0;
    result_ready = 1; result_data = 32'hFFFF_0000;
    tick();
    result_ready = 0;
    tick();
    apply_stimulus(5'd12, 1, 0, 32'hCAFE_F00D, 0, 1, 0, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      apply_stimulus(rd, 1'($urandom), 1'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0),
                     $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check_output("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
